// File: rtl/pll_lock_monitor_if.sv
// rtl/pll_lock_monitor_if.sv - PLL lock monitor status interface
// Carries the lock input and the qualified reset / status outputs.
`timescale 1ns/1ps
interface pll_lock_monitor_if;
    logic       pll_lock;
    logic       rst_out_n;
    logic [7:0] lock_lost_cnt;
    logic [2:0] led_out;

    modport master (
        output pll_lock,
        input  rst_out_n,
        input  lock_lost_cnt,
        input  led_out
    );

    modport slave (
        input  pll_lock,
        output rst_out_n,
        output lock_lost_cnt,
        output led_out
    );
endinterface

// File: rtl/pll_lock_monitor.sv
// rtl/pll_lock_monitor.sv - PLL lock qualifier producing a debounced downstream reset
// Optional lock-loss counter enabled by macro PLL_LOCK_LOSS_CNT_EN.
`timescale 1ns/1ps
module pll_lock_monitor #(
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int BLINK_DIV     = 4194304
) (
    input logic               clk_in,
    input logic               rst_n,
    pll_lock_monitor_if.slave mon
);
    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] STABILIZE = 2'd1;
    localparam logic [1:0] RUN       = 2'd2;
    localparam logic [1:0] LOST      = 2'd3;

    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);
    localparam logic [23:0] BLINK_LAST  = 24'(BLINK_DIV - 1);

    logic        sync1;
    logic        lock_s;
    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [23:0] blink_cnt;
    logic        blink;
    logic        rst_q;
    logic        acquiring_nxt;
    logic [7:0]  lost_cnt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = STABILIZE;
                    cnt_nxt   = 16'd0;
                end
            end
            STABILIZE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = 16'd0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = 16'd0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nxt = LOST;
                    cnt_nxt   = 16'd0;
                end
            end
            default: begin
                // LOST holds off re-qualification regardless of lock_s
                if (cnt == HOLD_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = 16'd0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
        endcase
    end

    assign acquiring_nxt = (state_nxt == WAIT_LOCK) || (state_nxt == STABILIZE);

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            lock_s    <= 1'b0;
            state     <= WAIT_LOCK;
            cnt       <= 16'd0;
            blink_cnt <= 24'd0;
            blink     <= 1'b0;
            rst_q     <= 1'b0;
        end else begin
            sync1  <= mon.pll_lock;
            lock_s <= sync1;
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rst_q  <= (state_nxt == RUN);
            if (!acquiring_nxt) begin
                blink_cnt <= 24'd0;
                blink     <= 1'b0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= 24'd0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 24'd1;
            end
        end
    end

`ifdef PLL_LOCK_LOSS_CNT_EN
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            lost_cnt <= 8'd0;
        end else if (state == RUN && state_nxt == LOST && lost_cnt != 8'hff) begin
            lost_cnt <= lost_cnt + 8'd1;
        end
    end
`else
    assign lost_cnt = 8'd0;
`endif

    assign mon.rst_out_n     = rst_q;
    assign mon.lock_lost_cnt = lost_cnt;
    assign mon.led_out       = {(lost_cnt != 8'd0), blink, rst_q};
endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb/tb_pll_lock_monitor.sv - self-checking bench for pll_lock_monitor
`timescale 1ns/1ps
module tb_pll_lock_monitor;
    localparam int STABLE = 16;
    localparam int HOLD   = 4;
    localparam int DIV    = 8;
`ifdef PLL_LOCK_LOSS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;

    pll_lock_monitor_if mon_if();

    pll_lock_monitor #(
        .STABLE_CYCLES(STABLE),
        .HOLD_CYCLES  (HOLD),
        .BLINK_DIV    (DIV)
    ) dut (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .mon   (mon_if)
    );

    always #5 clk_in = ~clk_in;

    typedef enum int {P_WAIT, P_QUAL, P_RUN, P_HOLD} phase_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    phase_t phase   = P_WAIT;
    int     t       = 0;
    int     lock_hist[$];
    int     run_at      = 0;
    int     wait_at     = 0;
    int     acq_start   = 0;
    int     lost_events = 0;

    task automatic check(string tag, int obs, int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, t);
        end
    endtask

    // Deadline-based reference: qualification ends at an absolute edge number
    task automatic model_edge(bit lock, bit rn);
        int ls;
        t++;
        if (!rn) begin
            phase       = P_WAIT;
            lock_hist   = {0, 0};
            acq_start   = t;
            lost_events = 0;
        end else begin
            ls = lock_hist.pop_front();
            lock_hist.push_back(int'(lock));
            case (phase)
                P_WAIT: if (ls != 0) begin
                    phase  = P_QUAL;
                    run_at = t + STABLE;
                end
                P_QUAL: begin
                    if (ls == 0) phase = P_WAIT;
                    else if (t == run_at) phase = P_RUN;
                end
                P_RUN: if (ls == 0) begin
                    phase   = P_HOLD;
                    wait_at = t + HOLD;
                    lost_events++;
                end
                default: if (t == wait_at) begin
                    phase     = P_WAIT;
                    acq_start = t - 1;
                end
            endcase
        end
    endtask

    function automatic int exp_lost();
        if (!CNT_EN) return 0;
        return (lost_events > 255) ? 255 : lost_events;
    endfunction

    function automatic int exp_led();
        int led1;
        led1 = 0;
        if (phase == P_WAIT || phase == P_QUAL)
            led1 = ((t - acq_start) / DIV) % 2;
        return ((exp_lost() != 0) ? 4 : 0) + led1 * 2 + ((phase == P_RUN) ? 1 : 0);
    endfunction

    task automatic step(bit lock, bit rn);
        mon_if.pll_lock = lock;
        rst_n           = rn;
        @(posedge clk_in);
        model_edge(lock, rn);
        #1;
        check("rst_out_n", int'(mon_if.rst_out_n), (phase == P_RUN) ? 1 : 0);
        check("lock_lost_cnt", int'(mon_if.lock_lost_cnt), exp_lost());
        check("led_out", int'(mon_if.led_out), exp_led());
    endtask

    initial begin
        lock_hist       = {0, 0};
        mon_if.pll_lock = 1'b0;

        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("reset_led", int'(mon_if.led_out), 0);

        // Power-up qualification and blink timing
        for (int i = 1; i <= 25; i++) begin
            step(1'b1, 1'b1);
            if (i == 7)  check("blink_e7", int'(mon_if.led_out[1]), 0);
            if (i == 8)  check("blink_e8", int'(mon_if.led_out[1]), 1);
            if (i == 15) check("blink_e15", int'(mon_if.led_out[1]), 1);
            if (i == 16) check("blink_e16", int'(mon_if.led_out[1]), 0);
            if (i == 18) check("qual_e18", int'(mon_if.rst_out_n), 0);
            if (i == 19) check("qual_e19", int'(mon_if.rst_out_n), 1);
        end

        // Lock loss from RUN, lock back immediately
        step(1'b0, 1'b1);
        check("loss_k", int'(mon_if.rst_out_n), 1);
        step(1'b1, 1'b1);
        check("loss_k1", int'(mon_if.rst_out_n), 1);
        step(1'b1, 1'b1);
        check("loss_k2", int'(mon_if.rst_out_n), 0);
        check("loss_cnt1", int'(mon_if.lock_lost_cnt), CNT_EN ? 1 : 0);
        check("loss_led2", int'(mon_if.led_out[2]), CNT_EN ? 1 : 0);
        for (int i = 3; i <= 23; i++) begin
            step(1'b1, 1'b1);
            if (i == 22) check("requal_e22", int'(mon_if.rst_out_n), 0);
            if (i == 23) check("requal_e23", int'(mon_if.rst_out_n), 1);
        end

        // Single-cycle glitch during STABILIZE restarts qualification
        step(1'b1, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            step((i != 14), 1'b1);
            if (i == 19) check("glitch_e19", int'(mon_if.rst_out_n), 0);
            if (i == 32) check("glitch_e32", int'(mon_if.rst_out_n), 0);
            if (i == 33) check("glitch_e33", int'(mon_if.rst_out_n), 1);
        end

        // Three losses, then reset from RUN
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b1);
            repeat (24) step(1'b1, 1'b1);
        end
        check("three_losses", int'(mon_if.lock_lost_cnt), CNT_EN ? 3 : 0);
        step(1'b1, 1'b0);
        check("rst_mid_out", int'(mon_if.rst_out_n), 0);
        check("rst_mid_cnt", int'(mon_if.lock_lost_cnt), 0);
        check("rst_mid_led", int'(mon_if.led_out), 0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b1);
            if (i == 18) check("rst_requal_e18", int'(mon_if.rst_out_n), 0);
            if (i == 19) check("rst_requal_e19", int'(mon_if.rst_out_n), 1);
        end

        // Saturation of the loss counter
        for (int c = 0; c < 300; c++) begin
            step(1'b0, 1'b1);
            repeat (24) step(1'b1, 1'b1);
        end
        check("sat_cnt", int'(mon_if.lock_lost_cnt), CNT_EN ? 255 : 0);
        check("sat_led2", int'(mon_if.led_out[2]), CNT_EN ? 1 : 0);

        // Randomized lock behaviour with occasional resets
        for (int s = 0; s < 300; s++) begin
            int kind;
            int len;
            kind = int'($urandom_range(0, 5));
            case (kind)
                0: begin
                    len = int'($urandom_range(1, 40));
                    repeat (len) step(1'b1, 1'b1);
                end
                1: begin
                    len = int'($urandom_range(1, 6));
                    repeat (len) step(1'b0, 1'b1);
                end
                2: step(1'b0, 1'b1);
                3: step(1'($urandom_range(0, 1)), 1'b0);
                4: repeat (30) step(1'b1, 1'b1);
                default: begin
                    len = int'($urandom_range(1, 10));
                    repeat (len) step(1'($urandom_range(0, 1)), 1'b1);
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
